imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The module SHALL have parameter IN_W, default 16, meaning immediate input width in bits (legal 2..OUT_W-2).
REQ-002 The module SHALL have parameter OUT_W, default 32, meaning extended output width in bits.
REQ-003 The module SHALL have parameter DEPTH, default 2, meaning output buffer entries (legal 1..8).
REQ-004 The module SHALL have parameter TAG_W, default 5, meaning sideband tag width (destination register index).
REQ-005 Port: clk  input  1  single clock, all state on rising edge.
REQ-006 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: in_valid  input  1  input transfer request.
REQ-008 Port: in_ready  output  1  buffer can accept one entry.
REQ-009 Port: in_imm  input  IN_W  raw immediate.
REQ-010 Port: in_mode  input  2  extension mode (see REQ-016).
REQ-011 Port: in_tag  input  TAG_W  tag carried unchanged alongside the result.
REQ-012 Port: out_valid  output  1  head entry valid.
REQ-013 Port: out_ready  input  1  consumer accepts head entry.
REQ-014 Port: out_data  output  OUT_W  extended result of head entry.
REQ-015 Port: out_tag  output  TAG_W  tag of head entry; out_count  output  4  current occupancy (0..DEPTH).

Function
REQ-016 Mode encoding SHALL be: 0 ZERO = {zeros, imm}; 1 SIGN = imm[IN_W-1] replicated into upper OUT_W-IN_W bits; 2 UPPER = imm placed in bits [OUT_W-1 : OUT_W-IN_W], lower bits zero; 3 BRANCH = SIGN result shifted left 2, top 2 bits discarded, bits [1:0] zero.
REQ-017 Extension SHALL be computed combinationally at input and stored already extended; an accepted input SHALL appear at out_data no earlier than the next cycle (latency 1 cycle when empty).
REQ-018 Input transfer occurs on a clk edge with in_valid && in_ready; output transfer occurs on a clk edge with out_valid && out_ready.
REQ-019 Buffer SHALL be FIFO-ordered; results SHALL leave in acceptance order with their own tags.
REQ-020 in_ready SHALL be 1 when out_count < DEPTH, or when out_count == DEPTH and out_ready && out_valid (simultaneous pop frees a slot same cycle).
REQ-021 out_valid SHALL equal (out_count != 0); out_data/out_tag SHALL hold stable while out_valid && !out_ready.
REQ-022 Simultaneous push and pop SHALL leave out_count unchanged; push only +1; pop only -1.
REQ-023 Read/write pointers SHALL wrap from DEPTH-1 to 0; non-power-of-two DEPTH SHALL be supported.
REQ-024 in_valid while !in_ready SHALL NOT modify state; upstream holds data.
REQ-025 When empty, out_data and out_tag SHALL be driven to zero.
REQ-026 Sustained throughput SHALL be one transfer per cycle with out_ready held 1, for any DEPTH.

Reset
REQ-027 rst_n low SHALL immediately clear out_count to 0, pointers to 0, out_valid to 0, out_data/out_tag to 0; in_ready SHALL read 1 while rst_n is high and the buffer is empty.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries; no partial entry survives deassertion.

Structure
REQ-029 Mode encodings (MODE_ZERO, MODE_SIGN, MODE_UPPER, MODE_BRANCH) SHALL be defined in the shared package imm_pkg, together with default IN_W/OUT_W.
REQ-030 The combinational extender SHALL be a sub-module imm_ext_core (in_imm, in_mode -> extended word, parametrised IN_W/OUT_W); imm_extend_pipe instantiates it plus the FIFO storage.

Verification
REQ-031 Reset, then push imm=16'h8001 in each mode with out_ready=1 -> out_data 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004 in order, one per cycle after latency 1.
REQ-032 imm=16'h7FFF, mode SIGN -> 32'h00007FFF; mode BRANCH -> 32'h0001FFFC.
REQ-033 DEPTH=2, out_ready=0, push tags 3,4 -> out_count=2, in_ready=0; third push held; then out_ready=1 same cycle as held push -> tag 3 pops, tag 5 accepted, count stays 2.
REQ-034 DEPTH=3, stream 10 entries with random out_ready stalls -> all 10 emerge in order with correct tags, pointers wrap cleanly.
REQ-035 Fill to 2 entries, assert rst_n=0 between edges -> out_valid=0, out_count=0 immediately; after release, first new push emerges with no stale data.
REQ-036 Parameter sweep IN_W=12, OUT_W=20, mode SIGN, imm=12'h800 -> out_data 20'hFF800.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: shared extension-mode encodings and default widths for the immediate extender.
package imm_pkg;
    localparam int IMM_IN_W  = 16;
    localparam int IMM_OUT_W = 32;
    typedef enum logic [1:0] {
        MODE_ZERO   = 2'd0,
        MODE_SIGN   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } imm_mode_e;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational zero/sign/upper/branch extension of a raw immediate.
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W
) (
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic [OUT_W-1:0] out_ext
);
    localparam int EW = OUT_W - IN_W;
    logic [OUT_W-1:0] zero_x, sign_x, upper_x, branch_x;
    assign zero_x   = {{EW{1'b0}}, in_imm};
    assign sign_x   = {{EW{in_imm[IN_W-1]}}, in_imm};
    assign upper_x  = {in_imm, {EW{1'b0}}};
    assign branch_x = {sign_x[OUT_W-3:0], 2'b00};
    assign out_ext  = in_mode == MODE_ZERO  ? zero_x  :
                      in_mode == MODE_SIGN  ? sign_x  :
                      in_mode == MODE_UPPER ? upper_x : branch_x;
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: extends immediates on entry and buffers them with their tags in a small FIFO.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [3:0] FULL = 4'(DEPTH);
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0] count_q, count_d;
    logic push, pop;

    imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .in_imm (in_imm),
        .in_mode(in_mode),
        .out_ext(ext)
    );

    // a full buffer still accepts when its head leaves in the same cycle
    assign in_ready  = count_q < FULL || out_ready;
    assign out_valid = count_q != 4'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_count = count_q;
    assign out_data  = out_valid ? data_q[rd_ptr_q] : '0;
    assign out_tag   = out_valid ? tag_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = push && !pop ? count_q + 4'd1 :
                   pop && !push ? count_q - 4'd1 : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= ext;
            tag_q[wr_ptr_q]  <= in_tag;
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed checks of extension modes, FIFO flow control, reset and width sweep.
module tb_imm_extend_pipe;
    import imm_pkg::*;

    logic clk, rst_n;
    int vectors = 0;
    int miscompares = 0;

    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_imm;
    logic [1:0] a_in_mode;
    logic [4:0] a_in_tag, a_out_tag;
    logic [31:0] a_out_data;
    logic [3:0] a_out_count;

    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_imm;
    logic [1:0] b_in_mode;
    logic [4:0] b_in_tag, b_out_tag;
    logic [31:0] b_out_data;
    logic [3:0] b_out_count;

    logic c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [11:0] c_in_imm;
    logic [1:0] c_in_mode;
    logic [4:0] c_in_tag, c_out_tag;
    logic [19:0] c_out_data;
    logic [3:0] c_out_count;

    imm_extend_pipe u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_imm(a_in_imm), .in_mode(a_in_mode), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_tag(a_out_tag), .out_count(a_out_count)
    );

    imm_extend_pipe #(.DEPTH(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_imm(b_in_imm), .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_count(b_out_count)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(20)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_imm(c_in_imm), .in_mode(c_in_mode), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_tag(c_out_tag), .out_count(c_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] imm_of(input int n);
        return 16'(32'h0F0F + n * 257);
    endfunction

    logic [31:0] e031 [4];
    int sent, rcv;

    initial begin
        e031 = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
        rst_n = 1'b0;
        {a_in_valid, a_out_ready, a_in_imm, a_in_mode, a_in_tag} = '0;
        {b_in_valid, b_out_ready, b_in_imm, b_in_mode, b_in_tag} = '0;
        {c_in_valid, c_out_ready, c_in_imm, c_in_mode, c_in_tag} = '0;
        #3;
        chk("rst_count", 32'(a_out_count), 32'd0);
        chk("rst_valid", 32'(a_out_valid), 32'd0);
        chk("rst_data", a_out_data, 32'd0);
        chk("rst_tag", 32'(a_out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(a_in_ready), 32'd1);

        // all four modes on 16'h8001, one per cycle
        @(negedge clk);
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        a_in_imm = 16'h8001;
        a_in_mode = MODE_ZERO;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("modes_8001", a_out_data, e031[i-1]);
            if (i < 4) a_in_mode = 2'(i);
            else a_in_valid = 1'b0;
        end
        @(negedge clk);
        chk("drain_valid", 32'(a_out_valid), 32'd0);
        chk("drain_data", a_out_data, 32'd0);

        // positive immediate: sign and branch
        a_in_valid = 1'b1;
        a_in_imm = 16'h7FFF;
        a_in_mode = MODE_SIGN;
        @(negedge clk);
        chk("sign_7fff", a_out_data, 32'h00007FFF);
        a_in_mode = MODE_BRANCH;
        @(negedge clk);
        chk("branch_7fff", a_out_data, 32'h0001FFFC);
        a_in_valid = 1'b0;
        @(negedge clk);

        // full buffer, held push, simultaneous push/pop
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_mode = MODE_ZERO;
        a_in_imm = 16'd3;
        a_in_tag = 5'd3;
        @(negedge clk);
        a_in_imm = 16'd4;
        a_in_tag = 5'd4;
        @(negedge clk);
        a_in_imm = 16'd5;
        a_in_tag = 5'd5;
        #1;
        chk("full_count", 32'(a_out_count), 32'd2);
        chk("full_in_ready", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("held_count", 32'(a_out_count), 32'd2);
        chk("held_head_tag", 32'(a_out_tag), 32'd3);
        a_out_ready = 1'b1;
        #1 chk("pop_frees_ready", 32'(a_in_ready), 32'd1);
        @(negedge clk);
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        #1;
        chk("swap_count", 32'(a_out_count), 32'd2);
        chk("swap_head_tag", 32'(a_out_tag), 32'd4);
        chk("swap_head_data", a_out_data, 32'd4);
        a_out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("tail_tag", 32'(a_out_tag), 32'd5);
        chk("tail_data", a_out_data, 32'd5);
        chk("tail_count", 32'(a_out_count), 32'd1);
        @(negedge clk);
        chk("tail_empty", 32'(a_out_count), 32'd0);

        // DEPTH=3 streaming with stalls
        sent = 0;
        rcv = 0;
        b_in_mode = MODE_ZERO;
        for (int cyc = 0; cyc < 300 && rcv < 10; cyc++) begin
            @(negedge clk);
            b_in_valid = sent < 10;
            b_in_imm = imm_of(sent);
            b_in_tag = 5'(sent + 10);
            b_out_ready = cyc < 5 ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            if (cyc == 4) begin
                chk("d3_full_count", 32'(b_out_count), 32'd3);
                chk("d3_full_ready", 32'(b_in_ready), 32'd0);
            end
            if (b_out_valid && b_out_ready) begin
                chk("d3_data", b_out_data, {16'h0, imm_of(rcv)});
                chk("d3_tag", 32'(b_out_tag), 32'(rcv + 10));
                rcv++;
            end
            if (b_in_valid && b_in_ready) sent++;
        end
        b_in_valid = 1'b0;
        chk("d3_all_out", 32'(rcv), 32'd10);

        // reset mid-operation
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_imm = 16'hAAAA;
        a_in_tag = 5'd1;
        @(negedge clk);
        a_in_imm = 16'hBBBB;
        a_in_tag = 5'd2;
        @(negedge clk);
        a_in_valid = 1'b0;
        #1 chk("pre_rst_count", 32'(a_out_count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
        chk("mid_rst_count", 32'(a_out_count), 32'd0);
        chk("mid_rst_data", a_out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        a_in_imm = 16'h1234;
        a_in_tag = 5'd7;
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        chk("post_rst_data", a_out_data, 32'h00001234);
        chk("post_rst_tag", 32'(a_out_tag), 32'd7);
        chk("post_rst_count", 32'(a_out_count), 32'd1);
        @(negedge clk);
        chk("post_rst_empty", 32'(a_out_valid), 32'd0);

        // IN_W=12 / OUT_W=20 instance
        c_out_ready = 1'b1;
        c_in_valid = 1'b1;
        c_in_imm = 12'h800;
        c_in_mode = MODE_SIGN;
        @(negedge clk);
        chk("w12_sign", 32'(c_out_data), 32'h000FF800);
        c_in_mode = MODE_BRANCH;
        @(negedge clk);
        chk("w12_branch", 32'(c_out_data), 32'h000FE000);
        c_in_mode = MODE_UPPER;
        @(negedge clk);
        chk("w12_upper", 32'(c_out_data), 32'h00080000);
        c_in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
